decode_stage: RTL and testbench

Registered, flow-controlled instruction decode stage for the 16-bit core ISA. It accepts one instruction word per cycle over a valid/ready handshake and splits it into opcode, register addresses, function, immediate and address fields. Immediate and address are sign-extended to parametrised widths, and opcodes outside a legal set are flagged. A 2-entry output buffer decouples fetch from execute back-pressure, with flush support and a retired-instruction counter. It sits between fetch and the register file/ALU.

---
 rtl/decode_stage_if.sv | 49 ++++
 rtl/decode_stage.sv | 135 +++++++++++++
 tb/tb_decode_stage.sv | 244 ++++++++++++++++++++++++
 3 files changed

// File: rtl/decode_stage_if.sv
`default_nettype none
// ============================================================================
// Module   : decode_stage_if
// Purpose  : Bundles the decode stage's fetch-side handshake, flush, and the
//            decoded output bundle with its consumer handshake.
// Modports : slave  - the decode stage itself
//            master - the environment driving fetch and consuming results
// Signals  : in_valid/in_ready/inst   fetch handshake + instruction word
//            flush                    discard all buffered entries
//            out_valid/out_ready      consumer handshake on head entry
//            opcode, rd_addr, ra_addr, rb_addr, func, imm, addr, illegal
//                                     decoded head-entry fields
//            retired                  count of output handshakes
// Revision : 1.0 - initial release
// ============================================================================
interface decode_stage_if #(
   parameter int IMM_W  = 8,
   parameter int ADDR_W = 8,
   parameter int CNT_W  = 16
);
   logic              in_valid;
   logic              in_ready;
   logic [15:0]       inst;
   logic              flush;
   logic              out_valid;
   logic              out_ready;
   logic [3:0]        opcode;
   logic [2:0]        rd_addr;
   logic [2:0]        ra_addr;
   logic [2:0]        rb_addr;
   logic [2:0]        func;
   logic [IMM_W-1:0]  imm;
   logic [ADDR_W-1:0] addr;
   logic              illegal;
   logic [CNT_W-1:0]  retired;

   modport slave (
      input  in_valid, inst, flush, out_ready,
      output in_ready, out_valid, opcode, rd_addr, ra_addr, rb_addr,
             func, imm, addr, illegal, retired
   );

   modport master (
      output in_valid, inst, flush, out_ready,
      input  in_ready, out_valid, opcode, rd_addr, ra_addr, rb_addr,
             func, imm, addr, illegal, retired
   );
endinterface
`default_nettype wire

// File: rtl/decode_stage.sv
`default_nettype none
// ============================================================================
// Module   : decode_stage
// Purpose  : Registered, flow-controlled decode of 16-bit instruction words
//            into opcode/register/function/immediate/address fields, with a
//            2-entry output buffer, flush, and a retired-instruction counter.
// Ports    : clk    - sole clock, rising edge
//            rst_n  - asynchronous active-low reset
//            bus    - decode_stage_if.slave (fetch handshake, flush,
//                     decoded head bundle, consumer handshake, retired)
// Revision : 1.0 - initial release
// ============================================================================
module decode_stage #(
   parameter int          IMM_W     = 8,
   parameter int          ADDR_W    = 8,
   parameter logic [15:0] LEGAL_OPS = 16'hFFFF,
   parameter int          CNT_W     = 16
) (
   input  logic           clk,
   input  logic           rst_n,
   decode_stage_if.slave  bus
);

   if (IMM_W < 6) begin : g_imm_w_check
      $error("decode_stage: IMM_W must be at least 6");
   end
   if (ADDR_W < 7) begin : g_addr_w_check
      $error("decode_stage: ADDR_W must be at least 7");
   end

   typedef struct packed {
      logic [3:0]        opcode;
      logic [2:0]        rd;
      logic [2:0]        ra;
      logic [2:0]        rb;
      logic [2:0]        func;
      logic [IMM_W-1:0]  imm;
      logic [ADDR_W-1:0] addr;
      logic              illegal;
   } entry_t;

   entry_t           mem_q [2];
   entry_t           mem_d [2];
   entry_t           head_q;
   entry_t           head_d;
   entry_t           dec_entry;
   logic             wr_ptr_q, wr_ptr_d;
   logic             rd_ptr_q, rd_ptr_d;
   logic [1:0]       count_q, count_d;
   logic [CNT_W-1:0] retired_q, retired_d;
   logic [5:0]       imm6;
   logic             push;
   logic             pop;

   // Handshake status depends only on occupancy, so in_ready never waits
   // on the consumer.
   assign bus.in_ready  = (count_q != 2'd2);
   assign bus.out_valid = (count_q != 2'd0);

   assign push = bus.in_valid  && bus.in_ready;
   assign pop  = bus.out_valid && bus.out_ready;

   // Decode happens at write time; the buffer stores finished bundles.
   always_comb begin
      imm6                = {bus.inst[11:9], bus.inst[2:0]};
      dec_entry           = '0;
      dec_entry.opcode    = bus.inst[15:12];
      dec_entry.rd        = bus.inst[11:9];
      dec_entry.ra        = bus.inst[8:6];
      dec_entry.rb        = bus.inst[5:3];
      dec_entry.func      = bus.inst[2:0];
      dec_entry.imm       = IMM_W'($signed(imm6));
      dec_entry.addr      = ADDR_W'($signed(bus.inst[6:0]));
      dec_entry.illegal   = ~LEGAL_OPS[bus.inst[15:12]];
   end

   always_comb begin
      mem_d     = mem_q;
      wr_ptr_d  = wr_ptr_q;
      rd_ptr_d  = rd_ptr_q;
      count_d   = count_q;
      retired_d = retired_q;
      if (bus.flush) begin
         // Flush wins over a same-cycle push and pop; neither is recorded.
         count_d  = 2'd0;
         wr_ptr_d = 1'b0;
         rd_ptr_d = 1'b0;
      end else begin
         if (push) begin
            mem_d[wr_ptr_q] = dec_entry;
            wr_ptr_d        = ~wr_ptr_q;
         end
         if (pop) begin
            rd_ptr_d  = ~rd_ptr_q;
            retired_d = retired_q + CNT_W'(1);
         end
         count_d = count_q + 2'(push) - 2'(pop);
      end
      // The output register tracks the new head; with the buffer empty it
      // keeps the last head so the outputs never show stale slot contents.
      head_d = (count_d != 2'd0) ? mem_d[rd_ptr_d] : head_q;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < 2; i++) begin
            mem_q[i] <= '0;
         end
         head_q    <= '0;
         wr_ptr_q  <= 1'b0;
         rd_ptr_q  <= 1'b0;
         count_q   <= 2'd0;
         retired_q <= '0;
      end else begin
         mem_q     <= mem_d;
         head_q    <= head_d;
         wr_ptr_q  <= wr_ptr_d;
         rd_ptr_q  <= rd_ptr_d;
         count_q   <= count_d;
         retired_q <= retired_d;
      end
   end

   assign bus.opcode  = head_q.opcode;
   assign bus.rd_addr = head_q.rd;
   assign bus.ra_addr = head_q.ra;
   assign bus.rb_addr = head_q.rb;
   assign bus.func    = head_q.func;
   assign bus.imm     = head_q.imm;
   assign bus.addr    = head_q.addr;
   assign bus.illegal = head_q.illegal;
   assign bus.retired = retired_q;

endmodule
`default_nettype wire

// File: tb/tb_decode_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_decode_stage
// Purpose  : Directed self-checking bench for decode_stage. Two instances
//            share one stimulus stream: u_dut0 uses default parameters,
//            u_dut1 uses ADDR_W=12, LEGAL_OPS=16'h00FF, CNT_W=4.
// Revision : 1.0 - initial release
// ============================================================================
module tb_decode_stage;

   logic        clk;
   logic        rst_n;
   logic        in_valid;
   logic [15:0] inst;
   logic        flush;
   logic        out_ready;

   int n_checks;
   int n_fail;

   decode_stage_if #(.IMM_W(8), .ADDR_W(8),  .CNT_W(16)) vif0 ();
   decode_stage_if #(.IMM_W(8), .ADDR_W(12), .CNT_W(4))  vif1 ();

   assign vif0.in_valid  = in_valid;
   assign vif0.inst      = inst;
   assign vif0.flush     = flush;
   assign vif0.out_ready = out_ready;
   assign vif1.in_valid  = in_valid;
   assign vif1.inst      = inst;
   assign vif1.flush     = flush;
   assign vif1.out_ready = out_ready;

   decode_stage #(
      .IMM_W(8), .ADDR_W(8), .LEGAL_OPS(16'hFFFF), .CNT_W(16)
   ) u_dut0 (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (vif0)
   );

   decode_stage #(
      .IMM_W(8), .ADDR_W(12), .LEGAL_OPS(16'h00FF), .CNT_W(4)
   ) u_dut1 (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (vif1)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] got,
                           input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Advance one clock and settle just after the edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check_head(input string tag, input logic [3:0] op,
                             input logic [2:0] fn, input logic vld);
      check_eq({tag, "_valid0"}, 32'(vif0.out_valid), 32'(vld));
      check_eq({tag, "_op0"},    32'(vif0.opcode),    32'(op));
      check_eq({tag, "_func0"},  32'(vif0.func),      32'(fn));
      check_eq({tag, "_op1"},    32'(vif1.opcode),    32'(op));
   endtask

   initial begin
      n_checks  = 0;
      n_fail    = 0;
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      inst      = 16'h0000;
      flush     = 1'b0;
      out_ready = 1'b0;

      // ---------------- reset state ----------------
      #3;
      check_eq("rst_valid",   32'(vif0.out_valid), 32'h0);
      check_eq("rst_ready",   32'(vif0.in_ready),  32'h1);
      check_eq("rst_opcode",  32'(vif0.opcode),    32'h0);
      check_eq("rst_imm",     32'(vif0.imm),       32'h0);
      check_eq("rst_addr1",   32'(vif1.addr),      32'h0);
      check_eq("rst_illegal", 32'(vif1.illegal),   32'h0);
      check_eq("rst_retired", 32'(vif0.retired),   32'h0);
      in_valid = 1'b1;
      inst     = 16'h1A3F;
      step();
      check_eq("rst_hold_valid", 32'(vif0.out_valid), 32'h0);
      rst_n    = 1'b1;
      in_valid = 1'b0;
      step();

      // ---------------- basic decode 16'h1A3F ----------------
      out_ready = 1'b1;
      in_valid  = 1'b1;
      inst      = 16'h1A3F;
      step();
      in_valid  = 1'b0;
      check_eq("d1_valid",  32'(vif0.out_valid), 32'h1);
      check_eq("d1_opcode", 32'(vif0.opcode),    32'h1);
      check_eq("d1_rd",     32'(vif0.rd_addr),   32'h5);
      check_eq("d1_ra",     32'(vif0.ra_addr),   32'h0);
      check_eq("d1_rb",     32'(vif0.rb_addr),   32'h7);
      check_eq("d1_func",   32'(vif0.func),      32'h7);
      check_eq("d1_imm",    32'(vif0.imm),       32'hEF);
      check_eq("d1_addr0",  32'(vif0.addr),      32'h3F);
      check_eq("d1_addr1",  32'(vif1.addr),      32'h03F);
      check_eq("d1_ill0",   32'(vif0.illegal),   32'h0);
      check_eq("d1_ill1",   32'(vif1.illegal),   32'h0);
      check_eq("d1_ret_pre",32'(vif0.retired),   32'h0);
      step();
      check_eq("d1_ret0",    32'(vif0.retired),   32'h1);
      check_eq("d1_ret1",    32'(vif1.retired),   32'h1);
      check_eq("d1_empty",   32'(vif0.out_valid), 32'h0);
      check_eq("d1_hold_op", 32'(vif0.opcode),    32'h1);
      check_eq("d1_hold_imm",32'(vif0.imm),       32'hEF);

      // ---------------- negative address 16'h0040 ----------------
      in_valid = 1'b1;
      inst     = 16'h0040;
      step();
      in_valid = 1'b0;
      check_eq("d2_imm",   32'(vif0.imm),  32'h00);
      check_eq("d2_addr0", 32'(vif0.addr), 32'hC0);
      check_eq("d2_addr1", 32'(vif1.addr), 32'hFC0);
      step();
      check_eq("d2_ret0",  32'(vif0.retired), 32'h2);

      // ---------------- illegal opcode 16'hF000 ----------------
      in_valid = 1'b1;
      inst     = 16'hF000;
      step();
      in_valid = 1'b0;
      check_eq("d3_opcode", 32'(vif1.opcode),  32'hF);
      check_eq("d3_ill0",   32'(vif0.illegal), 32'h0);
      check_eq("d3_ill1",   32'(vif1.illegal), 32'h1);
      step();
      check_eq("d3_ret1",   32'(vif1.retired), 32'h3);

      // ---------------- back-pressure A, B, C ----------------
      out_ready = 1'b0;
      in_valid  = 1'b1;
      inst      = 16'h2001;             // A
      step();
      check_eq("bp_ready_a", 32'(vif0.in_ready), 32'h1);
      check_head("bp_a", 4'h2, 3'h1, 1'b1);
      inst = 16'h3002;                  // B
      step();
      check_eq("bp_ready_b", 32'(vif0.in_ready), 32'h0);
      check_head("bp_b", 4'h2, 3'h1, 1'b1);
      inst = 16'h4003;                  // C, must be held off
      step();
      check_eq("bp_ready_c", 32'(vif0.in_ready), 32'h0);
      check_head("bp_stable", 4'h2, 3'h1, 1'b1);
      out_ready = 1'b1;
      step();                           // pop A, C still blocked
      check_head("bp_out_b", 4'h3, 3'h2, 1'b1);
      check_eq("bp_ready_after", 32'(vif0.in_ready), 32'h1);
      step();                           // pop B, push C
      in_valid = 1'b0;
      check_head("bp_out_c", 4'h4, 3'h3, 1'b1);
      step();                           // pop C
      check_eq("bp_empty", 32'(vif0.out_valid), 32'h0);
      check_eq("bp_ret0",  32'(vif0.retired),   32'h6);

      // ---------------- flush at full occupancy ----------------
      out_ready = 1'b0;
      in_valid  = 1'b1;
      inst      = 16'h5000;
      step();
      inst      = 16'h6000;
      step();
      check_eq("fl_full", 32'(vif0.in_ready), 32'h0);
      flush     = 1'b1;
      inst      = 16'h7000;
      out_ready = 1'b1;
      step();
      flush     = 1'b0;
      in_valid  = 1'b0;
      check_eq("fl_valid",   32'(vif0.out_valid), 32'h0);
      check_eq("fl_ready",   32'(vif0.in_ready),  32'h1);
      check_eq("fl_ret0",    32'(vif0.retired),   32'h6);
      check_eq("fl_hold_op", 32'(vif0.opcode),    32'h5);
      step();
      check_eq("fl_no_push", 32'(vif0.out_valid), 32'h0);

      // ---------------- zero-bubble stream, then counter wrap ----------
      out_ready = 1'b1;
      in_valid  = 1'b1;
      for (int i = 1; i <= 9; i++) begin
         inst = {4'(i), 9'h000, 3'(i)};
         step();
         check_head("zb", 4'(i), 3'(i), 1'b1);
      end
      in_valid = 1'b0;
      step();
      check_eq("wr_ret1_15", 32'(vif1.retired), 32'hF);
      check_eq("wr_ret0_15", 32'(vif0.retired), 32'hF);
      in_valid = 1'b1;
      inst     = 16'h0008;
      step();
      in_valid = 1'b0;
      step();
      check_eq("wr_ret1_0",  32'(vif1.retired), 32'h0);
      check_eq("wr_ret0_16", 32'(vif0.retired), 32'h10);

      // ---------------- asynchronous reset mid-stream ----------------
      out_ready = 1'b0;
      in_valid  = 1'b1;
      inst      = 16'h9ABC;
      step();
      inst      = 16'hBABC;
      step();
      in_valid  = 1'b0;
      check_eq("ar_pre_ill1", 32'(vif1.illegal), 32'h1);
      #2;
      rst_n = 1'b0;
      #1;
      check_eq("ar_valid",   32'(vif0.out_valid), 32'h0);
      check_eq("ar_ready",   32'(vif0.in_ready),  32'h1);
      check_eq("ar_opcode",  32'(vif0.opcode),    32'h0);
      check_eq("ar_imm",     32'(vif0.imm),       32'h0);
      check_eq("ar_addr1",   32'(vif1.addr),      32'h0);
      check_eq("ar_ill1",    32'(vif1.illegal),   32'h0);
      check_eq("ar_ret0",    32'(vif0.retired),   32'h0);
      step();
      rst_n = 1'b1;
      step();
      check_eq("ar_post_valid", 32'(vif0.out_valid), 32'h0);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
